// File: rtl/cpa_pipe.sv
// Pipelined carry-propagate adder/subtractor with a valid/ready stream interface.
// Each stage adds one WIDTH/STAGES-bit segment; the carry and the operands travel stage to stage.
module cpa_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned SW = WIDTH / STAGES;

    // Rank k holds sum bits below segment k and operand bits from segment k upward.
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  w_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [STAGES-1:0] c_q;

    logic              out_valid_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  nxt_w [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic [SW:0]       seg;
    logic              msb_c;
    logic              stall;

    assign stall     = out_valid_q && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

    always_comb begin
        seg   = '0;
        nxt_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            seg = {1'b0, w_q[k][k*SW +: SW]} + {1'b0, b_q[k][k*SW +: SW]}
                + {{SW{1'b0}}, c_q[k]};
            nxt_w[k]             = w_q[k];
            nxt_w[k][k*SW +: SW] = seg[SW-1:0];
            nxt_c[k]             = seg[SW];
        end
        // Carry into the MSB recovered from the MSB's own sum bit.
        msb_c = w_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1] ^ nxt_w[STAGES-1][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (!stall) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            out_valid_q <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
                sum_q  <= nxt_w[STAGES-1];
                cout_q <= nxt_c[STAGES-1];
                ovf_q  <= msb_c ^ nxt_c[STAGES-1];
            end
        end
    end

    // Datapath ranks need no reset; only valid beats load them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            if (in_valid) begin
                w_q[0] <= a;
                b_q[0] <= op ? ~b : b;
                c_q[0] <= op | cin;
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (v_q[k]) begin
                    w_q[k+1] <= nxt_w[k];
                    b_q[k+1] <= b_q[k];
                    c_q[k+1] <= nxt_c[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpa_pipe.sv
// Self-checking bench for cpa_pipe: directed vectors, back-pressure, bubbles and mid-stream reset,
// with a scoreboard queue of model results popped on every output transfer.
module tb_cpa_pipe;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    logic [WIDTH+1:0] sb[$];

    always #5 clk = ~clk;

    cpa_pipe #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    // Reference: {sum, cout, overflow}; overflow from the operand/result sign rule.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic ci, input logic o);
        logic [WIDTH-1:0] yy;
        logic [WIDTH:0]   r;
        logic             v;
        yy = o ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, (o ? 1'b1 : ci)};
        v  = (x[WIDTH-1] == yy[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        return {r[WIDTH-1:0], r[WIDTH], v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge, then step past the next rising edge.
    task automatic tick();
        logic [WIDTH+1:0] e;
        @(negedge clk);
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_result", 32'({sum, cout, overflow}), 32'(e));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, cin, op));
        end
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipe; checks latency and the fixed expected result.
    task automatic directed(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, input logic o, input logic [WIDTH+1:0] exp);
        a        = x;
        b        = y;
        cin      = ci;
        op       = o;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (STAGES - 1) tick();
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'({sum, cout, overflow}), 32'(exp));
        tick();
    endtask

    logic [WIDTH-1:0] va[8];
    logic [WIDTH-1:0] vb[8];
    logic             vc[8];
    logic             vo[8];
    logic [WIDTH+1:0] snap;
    logic             pat[6];
    logic             acc;
    logic             seen;
    int               sent;
    int               stall_left;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        #1;
        chk("empty_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
        directed("carry_chain", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0});
        directed("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b1, {16'hFFFF, 1'b0, 1'b0});
        directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});

        // Back-to-back stream with a 3-cycle stall when the first result appears.
        for (int i = 0; i < 8; i++) begin
            va[i] = WIDTH'($urandom);
            vb[i] = WIDTH'($urandom);
            vc[i] = 1'($urandom);
            vo[i] = 1'($urandom);
        end
        sent       = 0;
        seen       = 1'b0;
        stall_left = 0;
        snap       = '0;
        for (int cyc = 0; cyc < 60 && (sent < 8 || sb.size() != 0); cyc++) begin
            if (!seen && out_valid) begin
                seen       = 1'b1;
                stall_left = 3;
                snap       = {sum, cout, overflow};
            end
            if (sent < 8) begin
                in_valid = 1'b1;
                a        = va[sent];
                b        = vb[sent];
                cin      = vc[sent];
                op       = vo[sent];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_hold", 32'({sum, cout, overflow}), 32'(snap));
                stall_left--;
            end else begin
                chk("run_in_ready", 32'(in_ready), 32'd1);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        chk("bp_drained", 32'(sent == 8 && sb.size() == 0 && seen), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b0;

        // Bubble pattern must reappear on out_valid STAGES cycles later.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int j = 0; j < 6 + STAGES; j++) begin
            in_valid = (j < 6) ? pat[j] : 1'b0;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            op       = 1'($urandom);
            tick();
            chk("bubble_valid", 32'(out_valid),
                32'((j >= STAGES && j - STAGES < 6) ? pat[j-STAGES] : 1'b0));
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // Three beats in flight, then a one-cycle reset discards them.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = 16'h1111 * 16'(i + 1);
            b        = 16'h0F0F;
            cin      = 1'b0;
            op       = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        for (int j = 0; j < STAGES + 2; j++) begin
            tick();
            chk("midrst_no_ghost", 32'(out_valid), 32'd0);
        end
        directed("post_rst", 16'h1234, 16'h0FED, 1'b1, 1'b0, {16'h2222, 1'b0, 1'b0});

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
